// File: rtl/multichannel_pan_mixer_pkg.sv
// Shared constants, channel config layout and arithmetic helpers for the pan mixer.
package mixer_pkg;

  localparam logic [7:0] CFG_RESET   = 8'hCF;
  localparam int         CFG_L       = 7;
  localparam int         CFG_R       = 6;
  localparam int         CFG_VOL_MSB = 3;

  typedef struct packed {
    logic       left_en;
    logic       right_en;
    logic [3:0] vol;
  } chan_cfg_t;

  // Full-scale volume is treated as unity gain (x16) so that >>>4 restores the input level.
  function automatic logic [4:0] vol_to_mult(input logic [3:0] vol);
    return (vol == 4'd15) ? 5'd16 : {1'b0, vol};
  endfunction

  function automatic logic [31:0] sat_offset(input int r, input int out_w);
    int hi;
    int lo;
    int c;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    c  = r;
    if (c > hi) c = hi;
    else if (c < lo) c = lo;
    return 32'(c + (1 << (out_w - 1)));
  endfunction

endpackage

// File: rtl/sd_dac_1bit.sv
// First-order sigma-delta modulator: 1-bit stream whose ones-density is din/2^W.
module sd_dac_1bit #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic         dout
);

  localparam logic [W+1:0] MID  = {2'b10, {W{1'b0}}};
  localparam logic [W+1:0] FULL = {2'b01, {W{1'b0}}};

  logic [W+1:0] acc;
  logic [W+1:0] acc_next;

  // Error feedback keeps acc within [MID-FULL, MID+FULL), so W+2 bits never wrap.
  assign acc_next = acc + {2'b00, din} - (dout ? FULL : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= MID;
      dout <= 1'b0;
    end else begin
      acc  <= acc_next;
      dout <= (acc_next >= MID);
    end
  end

endmodule

// File: rtl/multichannel_pan_mixer.sv
// Time-multiplexed NCH-channel stereo mixer with per-channel volume/pan and saturating output.
// Optional MIXER_SIGMA_DELTA_EN adds 1-bit sigma-delta DAC outputs dac_left/dac_right.
module multichannel_pan_mixer
  import mixer_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH*IN_W-1:0]     samples,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_addr,
  input  logic [7:0]              cfg_wdata,
  output logic [7:0]              cfg_rdata,
  output logic [OUT_W-1:0]        out_left,
  output logic [OUT_W-1:0]        out_right,
  output logic                    out_valid
`ifdef MIXER_SIGMA_DELTA_EN
  ,
  output logic                    dac_left,
  output logic                    dac_right
`endif
);

  localparam int                ADDR_W = $clog2(NCH);
  localparam int                SLOT_W = $clog2(NCH + 1);
  localparam int                ACC_W  = IN_W + 5 + $clog2(NCH);
  localparam logic [SLOT_W-1:0] LAST   = SLOT_W'(NCH);
  localparam logic [OUT_W-1:0]  MIDPT  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam chan_cfg_t         CFG_RST_S = '{left_en:  CFG_RESET[CFG_L],
                                              right_en: CFG_RESET[CFG_R],
                                              vol:      CFG_RESET[CFG_VOL_MSB:0]};

  chan_cfg_t                cfg [NCH];
  logic [SLOT_W-1:0]        slot;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W-1:0]  acc_r;
  logic [IN_W-1:0]          cur_sample;
  chan_cfg_t                cur_cfg;
  logic signed [ACC_W-1:0]  s_ext;
  logic signed [ACC_W-1:0]  m_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  sh_l;
  logic signed [ACC_W-1:0]  sh_r;
  logic                     unused_rsvd;

  assign unused_rsvd = ^cfg_wdata[5:4];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cur_sample = '0;
    cur_cfg    = '0;
    if (slot < LAST) begin
      cur_sample = samples[slot*IN_W +: IN_W];
      cur_cfg    = cfg[slot[ADDR_W-1:0]];
    end
  end

  // Flipping the MSB turns offset binary into two's complement.
  assign s_ext = ACC_W'(signed'({~cur_sample[IN_W-1], cur_sample[IN_W-2:0]}));
  assign m_ext = ACC_W'(signed'({1'b0, vol_to_mult(cur_cfg.vol)}));
  assign prod  = s_ext * m_ext;
  assign sh_l  = acc_l >>> 4;
  assign sh_r  = acc_r >>> 4;

  always_comb begin
    cfg_rdata = '0;
    if (32'(cfg_addr) < NCH)
      cfg_rdata = {cfg[cfg_addr].left_en, cfg[cfg_addr].right_en, 2'b00, cfg[cfg_addr].vol};
  end

  // NOTE: the config file is a handful of flops, so it is reset like any other state, not left as RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cfg[i] <= CFG_RST_S;
    end else if (cfg_we && (32'(cfg_addr) < NCH)) begin
      cfg[cfg_addr] <= '{left_en: cfg_wdata[CFG_L], right_en: cfg_wdata[CFG_R],
                         vol: cfg_wdata[CFG_VOL_MSB:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_left  <= MIDPT;
      out_right <= MIDPT;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (slot == LAST) begin
        slot      <= '0;
        out_left  <= OUT_W'(sat_offset(int'(sh_l), OUT_W));
        out_right <= OUT_W'(sat_offset(int'(sh_r), OUT_W));
        out_valid <= 1'b1;
      end else begin
        slot <= slot + 1'b1;
        if (slot == '0) begin
          acc_l <= cur_cfg.left_en  ? prod : '0;
          acc_r <= cur_cfg.right_en ? prod : '0;
        end else begin
          if (cur_cfg.left_en)  acc_l <= acc_l + prod;
          if (cur_cfg.right_en) acc_r <= acc_r + prod;
        end
      end
    end
  end

`ifdef MIXER_SIGMA_DELTA_EN
  sd_dac_1bit #(.W(OUT_W)) u_sd_left (
    .clk   (clk),
    .reset (reset),
    .din   (out_left),
    .dout  (dac_left)
  );

  sd_dac_1bit #(.W(OUT_W)) u_sd_right (
    .clk   (clk),
    .reset (reset),
    .din   (out_right),
    .dout  (dac_right)
  );
`endif

endmodule

// File: tb/tb_multichannel_pan_mixer.sv
// Scoreboard bench for multichannel_pan_mixer: a per-slot reference model pushes expected frames.
module tb_multichannel_pan_mixer;

  localparam int NCH   = 8;
  localparam int IN_W  = 8;
  localparam int OUT_W = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH*IN_W-1:0]  samples = '0;
  logic                 cfg_we = 1'b0;
  logic [2:0]           cfg_addr = '0;
  logic [7:0]           cfg_wdata = '0;
  logic [7:0]           cfg_rdata;
  logic [OUT_W-1:0]     out_left;
  logic [OUT_W-1:0]     out_right;
  logic                 out_valid;
`ifdef MIXER_SIGMA_DELTA_EN
  logic                 dac_left;
  logic                 dac_right;
`endif

  multichannel_pan_mixer #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .samples   (samples),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid)
`ifdef MIXER_SIGMA_DELTA_EN
    ,
    .dac_left  (dac_left),
    .dac_right (dac_right)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  logic [7:0] cfg_m [NCH];
  int         acc_l_m, acc_r_m, slot_m;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_v = -1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int vol_m(input logic [3:0] v);
    return (v == 4'd15) ? 16 : int'(v);
  endfunction

  function automatic int sat_off(input int r);
    int c;
    c = r;
    if (c > 511) c = 511;
    if (c < -512) c = -512;
    return c + 512;
  endfunction

  // Model the current slot with pre-edge config, then advance one clock.
  task automatic tick();
    int s, p;
    if (slot_m < NCH) begin
      s = int'(samples[slot_m*IN_W +: IN_W]) - 128;
      p = s * vol_m(cfg_m[slot_m][3:0]);
      if (slot_m == 0) begin
        acc_l_m = cfg_m[0][7] ? p : 0;
        acc_r_m = cfg_m[0][6] ? p : 0;
      end else begin
        if (cfg_m[slot_m][7]) acc_l_m += p;
        if (cfg_m[slot_m][6]) acc_r_m += p;
      end
    end else begin
      sb.push_back('{l: sat_off(acc_l_m >>> 4), r: sat_off(acc_r_m >>> 4)});
    end
    @(posedge clk);
    if (cfg_we) cfg_m[cfg_addr] = {cfg_wdata[7:6], 2'b00, cfg_wdata[3:0]};
    slot_m = (slot_m == NCH) ? 0 : slot_m + 1;
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic write_cfg(input int addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = data;
    tick();
  endtask

  task automatic run_frames(input int n);
    while (slot_m != 0) tick();
    repeat (n * (NCH + 1)) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) cfg_m[i] = 8'hCF;
    slot_m = 0; acc_l_m = 0; acc_r_m = 0;
    sb.delete();
    check("rst_left", int'(out_left), 512);
    check("rst_right", int'(out_right), 512);
    check("rst_valid", int'(out_valid), 0);
    for (int i = 0; i < NCH; i++) begin
      cfg_addr = 3'(i);
      #1;
      check("rst_rdata", int'(cfg_rdata), 8'hCF);
    end
  endtask

  function automatic logic [NCH*IN_W-1:0] fill(input logic [7:0] v);
    logic [NCH*IN_W-1:0] x;
    for (int i = 0; i < NCH; i++) x[i*IN_W +: IN_W] = v;
    return x;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      last_v = -1;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        got = sb.pop_front();
        check("left", int'(out_left), got.l);
        check("right", int'(out_right), got.r);
      end
      if (last_v >= 0) check("valid_period", cyc - last_v, NCH + 1);
      last_v = cyc;
    end
  end

  initial begin
    int ones_l, ones_r;
    do_reset();

    // Silence at midpoint, default config.
    samples = fill(8'h80);
    run_frames(3);

    // Left-only channel 0 at full scale, everything else muted.
    write_cfg(0, 8'h8F);
    for (int i = 1; i < NCH; i++) write_cfg(i, 8'h00);
    samples = {$urandom, $urandom};
    samples[7:0] = 8'hFF;
    run_frames(2);

    // Saturation in both directions.
    for (int i = 0; i < NCH; i++) write_cfg(i, 8'hCF);
    samples = fill(8'hFF);
    run_frames(2);
    samples = fill(8'h00);
    run_frames(2);

    // Right-only channel 3 at volume 7, then a volume-0 write after its slot.
    for (int i = 0; i < NCH; i++) write_cfg(i, (i == 3) ? 8'h47 : 8'h00);
    samples = {$urandom, $urandom};
    samples[3*IN_W +: IN_W] = 8'hC0;
    run_frames(2);
    while (slot_m != 5) tick();
    write_cfg(3, 8'h40);
    run_frames(2);

    // Write to a channel in the same cycle as its slot: old value must still apply.
    write_cfg(3, 8'h47);
    run_frames(1);
    while (slot_m != 3) tick();
    write_cfg(3, 8'hFF);
    run_frames(2);

    // Randomised samples every cycle with occasional config writes.
    for (int i = 0; i < 6 * (NCH + 1); i++) begin
      samples = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) write_cfg(int'($urandom_range(0, NCH - 1)), 8'($urandom));
      else tick();
    end

    // Mid-frame reset during slot 4 after non-midpoint outputs.
    for (int i = 0; i < NCH; i++) write_cfg(i, 8'hCF);
    samples = fill(8'hFF);
    run_frames(2);
    while (slot_m != 4) tick();
    do_reset();
    samples = fill(8'hC0);
    run_frames(2);

`ifdef MIXER_SIGMA_DELTA_EN
    samples = fill(8'hA0);
    run_frames(2);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones_l += int'(dac_left);
      ones_r += int'(dac_right);
    end
    check("sd_left_ones", (ones_l >= 3068 && ones_l <= 3076) ? 3072 : ones_l, 3072);
    check("sd_right_ones", (ones_r >= 3068 && ones_r <= 3076) ? 3072 : ones_r, 3072);
`else
    ones_l = 0;
    ones_r = 0;
`endif

    for (int i = 0; i < 4 * (NCH + 1) && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
